// File: rtl/nco_ctrl_pkg.sv
// Shared types for the NCO sweep sequencer.
// Holds the FSM state encoding, width defaults and the command bundle.
package nco_ctrl_pkg;

    localparam int PHW_DEF  = 32;
    localparam int CNTW_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_DWELL
    } state_t;

    typedef struct packed {
        logic [PHW_DEF-1:0]  start;
        logic [PHW_DEF-1:0]  step;
        logic [CNTW_DEF-1:0] count;
        logic [CNTW_DEF-1:0] dwell;
    } cmd_t;

endpackage

// File: rtl/nco_sweep_ctrl_timer.sv
// Loadable down-counter shared by the settle and dwell phases.
// Ports: clk, reset_n, load/load_val, en (decrement), term_o (count is 1).
module nco_ctrl_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         term_o
);

    logic [W-1:0] cnt_q;

    // Decrement stops at 1 so a stalled settle keeps its terminal flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q > W'(1))) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign term_o = (cnt_q == W'(1));

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Frequency sweep sequencer driving the mnco phase increment and clken.
// Ports: cmd_* handshake, abort, nco_out_valid_i; phi/clken/status outputs.
module nco_sweep_ctrl
    import nco_ctrl_pkg::*;
#(
    parameter int PHW     = PHW_DEF,
    parameter int CNTW    = CNTW_DEF,
    parameter int NCO_LAT = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [PHW-1:0]  cmd_start,
    input  logic [PHW-1:0]  cmd_step,
    input  logic [CNTW-1:0] cmd_count,
    input  logic [CNTW-1:0] cmd_dwell,
    input  logic            abort,
    input  logic            nco_out_valid_i,
    output logic [PHW-1:0]  phi_inc_o,
    output logic            nco_clken_o,
    output logic            settled_o,
    output logic [CNTW-1:0] step_idx_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            aborted_o
);

    state_t          state_q, state_d;
    logic [PHW-1:0]  phi_q, phi_d;
    logic [PHW-1:0]  step_q, step_d;
    logic [CNTW-1:0] idx_q, idx_d;
    logic [CNTW-1:0] count_q, count_d;
    logic [CNTW-1:0] dwell_q, dwell_d;
    logic            done_d, aborted_d;
    logic            busy_q, settled_q;
    logic            t_load, t_en, t_term;
    logic [CNTW-1:0] t_val;
    logic            accept;
    logic            last_pt;

    localparam logic [CNTW-1:0] LAT = CNTW'(NCO_LAT);

    assign cmd_ready = reset_n & ~abort & (state_q == ST_IDLE);
    assign accept    = cmd_valid & cmd_ready;
    assign last_pt   = ((idx_q + CNTW'(1)) == count_q);

    nco_ctrl_timer #(
        .W (CNTW)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (t_load),
        .load_val (t_val),
        .en       (t_en),
        .term_o   (t_term)
    );

    always_comb begin
        state_d   = state_q;
        phi_d     = phi_q;
        step_d    = step_q;
        idx_d     = idx_q;
        count_d   = count_q;
        dwell_d   = dwell_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        t_load    = 1'b0;
        t_val     = '0;
        t_en      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (cmd_count != '0) begin
                        step_d  = cmd_step;
                        count_d = cmd_count;
                        // A zero dwell still yields one settled cycle.
                        dwell_d = (cmd_dwell == '0) ? CNTW'(1) : cmd_dwell;
                        phi_d   = cmd_start;
                        idx_d   = '0;
                        t_load  = 1'b1;
                        t_val   = LAT;
                        state_d = ST_SETTLE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (t_term && nco_out_valid_i) begin
                    t_load  = 1'b1;
                    t_val   = dwell_q;
                    state_d = ST_DWELL;
                end else begin
                    t_en = 1'b1;
                end
            end
            ST_DWELL: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (t_term) begin
                    if (last_pt) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        phi_d   = phi_q + step_q;
                        idx_d   = idx_q + CNTW'(1);
                        t_load  = 1'b1;
                        t_val   = LAT;
                        state_d = ST_SETTLE;
                    end
                end else begin
                    t_en = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            phi_q     <= '0;
            step_q    <= '0;
            idx_q     <= '0;
            count_q   <= '0;
            dwell_q   <= '0;
            busy_q    <= 1'b0;
            settled_q <= 1'b0;
            done_o    <= 1'b0;
            aborted_o <= 1'b0;
        end else begin
            state_q   <= state_d;
            phi_q     <= phi_d;
            step_q    <= step_d;
            idx_q     <= idx_d;
            count_q   <= count_d;
            dwell_q   <= dwell_d;
            busy_q    <= (state_d != ST_IDLE);
            settled_q <= (state_d == ST_DWELL);
            done_o    <= done_d;
            aborted_o <= aborted_d;
        end
    end

    assign phi_inc_o   = phi_q;
    assign step_idx_o  = idx_q;
    assign busy_o      = busy_q;
    assign nco_clken_o = busy_q;
    assign settled_o   = settled_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Scoreboard bench for nco_sweep_ctrl.
// Expected settled/done/aborted events are queued at accept time.
module tb_nco_sweep_ctrl;
    import nco_ctrl_pkg::*;

    localparam int L = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_start;
    logic [31:0] cmd_step;
    logic [15:0] cmd_count;
    logic [15:0] cmd_dwell;
    logic        abort;
    logic        nco_valid;
    logic [31:0] phi_inc_o;
    logic        nco_clken_o;
    logic        settled_o;
    logic [15:0] step_idx_o;
    logic        busy_o;
    logic        done_o;
    logic        aborted_o;

    nco_sweep_ctrl #(
        .PHW     (32),
        .CNTW    (16),
        .NCO_LAT (L)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_start       (cmd_start),
        .cmd_step        (cmd_step),
        .cmd_count       (cmd_count),
        .cmd_dwell       (cmd_dwell),
        .abort           (abort),
        .nco_out_valid_i (nco_valid),
        .phi_inc_o       (phi_inc_o),
        .nco_clken_o     (nco_clken_o),
        .settled_o       (settled_o),
        .step_idx_o      (step_idx_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .aborted_o       (aborted_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 settled, 1 done, 2 aborted; idx -1 means not compared
    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] phi;
        int          idx;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  passed = 0;
    logic [31:0] model_phi = '0;

    task automatic chk(input string name, input bit ok,
                       input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s cyc=%0d actual=%0h required=%0h",
                      name, cyc, act, req);
    endtask

    function automatic int imax(int a, int b);
        return (a > b) ? a : b;
    endfunction

    function automatic cmd_t mk(logic [31:0] s, logic [31:0] st,
                                int n, int d);
        cmd_t c;
        c.start = s;
        c.step  = st;
        c.count = 16'(n);
        c.dwell = 16'(d);
        return c;
    endfunction

    // Monitor: every event cycle must match the head of the queue.
    ev_t m_e;
    int  m_k;
    bit  m_ok;
    always @(negedge clk) begin
        if (settled_o || done_o || aborted_o) begin
            m_k = (settled_o && !done_o && !aborted_o) ? 0 :
                  (done_o && !settled_o && !aborted_o) ? 1 :
                  (aborted_o && !settled_o && !done_o) ? 2 : 3;
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_event cyc=%0d kind=%0d phi=%0h",
                         cyc, m_k, phi_inc_o);
            end else begin
                m_e  = exp_q.pop_front();
                m_ok = (m_e.cyc == cyc) && (m_e.kind == m_k) &&
                       (phi_inc_o == m_e.phi) &&
                       (m_e.idx < 0 || int'(step_idx_o) == m_e.idx);
                if (m_ok) passed++;
                else $display({"FAIL event actual cyc=%0d kind=%0d ",
                               "phi=%0h idx=%0d required cyc=%0d kind=%0d ",
                               "phi=%0h idx=%0d"},
                              cyc, m_k, phi_inc_o, step_idx_o,
                              m_e.cyc, m_e.kind, m_e.phi, m_e.idx);
            end
        end
    end

    // Reference: point p has phase start+p*step; its dwell follows
    // NCO_LAT settle cycles (or the first valid cycle, if later).
    task automatic push_model(input int a, input cmd_t c, input int vcyc,
                              input int ax, output int endc);
        int d, se, e, pstart;
        logic [31:0] ph, cur;
        bit stop;
        ev_t ev;
        d = (c.dwell == 0) ? 1 : int'(c.dwell);
        if (c.count == 0) begin
            ev = '{cyc: a + 1, kind: 1, phi: model_phi, idx: -1};
            exp_q.push_back(ev);
            endc = a + 1;
            return;
        end
        cur    = c.start;
        se     = imax(a + L, vcyc);
        e      = se;
        pstart = a + 1;
        stop   = 0;
        for (int p = 0; p < int'(c.count) && !stop; p++) begin
            ph = c.start + c.step * 32'(p);
            if (ax >= 0 && pstart > ax) begin
                stop = 1;
            end else begin
                cur = ph;
                for (int k = 1; k <= d && !stop; k++) begin
                    if (ax >= 0 && se + k > ax) stop = 1;
                    else begin
                        ev = '{cyc: se + k, kind: 0, phi: ph, idx: p};
                        exp_q.push_back(ev);
                    end
                end
                e      = se + d;
                pstart = e + 1;
                se     = imax(e + L, vcyc);
            end
        end
        if (ax >= 0) begin
            ev = '{cyc: ax + 1, kind: 2, phi: cur, idx: -1};
            endc = ax + 1;
        end else begin
            ev = '{cyc: e + 1, kind: 1, phi: cur, idx: -1};
            endc = e + 1;
        end
        exp_q.push_back(ev);
        model_phi = cur;
    endtask

    // Starts and ends just after a rising edge.
    task automatic offer(input cmd_t c, output int a, output bit ok);
        int n;
        cmd_valid = 1'b1;
        cmd_start = c.start;
        cmd_step  = c.step;
        cmd_count = c.count;
        cmd_dwell = c.dwell;
        ok = 0;
        n  = 0;
        a  = 0;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1;
                a  = cyc;
            end else begin
                n++;
            end
        end
        if (!ok) chk("accept_timeout", 1'b0, 64'(cmd_ready), 64'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_start = $urandom;
        cmd_step  = $urandom;
        cmd_count = 16'($urandom);
        cmd_dwell = 16'($urandom);
    endtask

    task automatic run(input cmd_t c, input int voff, input int aoff);
        int a, endc;
        bit ok;
        if (voff > 0) nco_valid = 1'b0;
        offer(c, a, ok);
        if (!ok) begin
            nco_valid = 1'b1;
            return;
        end
        push_model(a, c, (voff > 0) ? a + voff : 0,
                   (aoff >= 0) ? a + aoff : -1, endc);
        if (c.count != 0) begin
            chk("start_phi", phi_inc_o == c.start, 64'(phi_inc_o),
                64'(c.start));
            chk("settle_flags", nco_clken_o && busy_o && !settled_o,
                {61'd0, nco_clken_o, busy_o, settled_o}, 64'd6);
        end else begin
            chk("count0_idle", !busy_o && !nco_clken_o,
                {62'd0, busy_o, nco_clken_o}, 64'd0);
        end
        while (cyc < endc) begin
            @(posedge clk);
            #1;
            if (voff > 0 && cyc == a + voff) nco_valid = 1'b1;
            abort = (aoff >= 0 && cyc == a + aoff);
        end
        abort     = 1'b0;
        nco_valid = 1'b1;
        chk("idle_after", !busy_o && !nco_clken_o && !settled_o,
            {61'd0, busy_o, nco_clken_o, settled_o}, 64'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a, n, d, ao;
        bit ok;
        cmd_t c;
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        abort     = 1'b0;
        nco_valid = 1'b1;
        cmd_start = '0;
        cmd_step  = '0;
        cmd_count = '0;
        cmd_dwell = '0;
        repeat (3) @(negedge clk);
        chk("reset_ready", cmd_ready == 1'b0, 64'(cmd_ready), 64'd0);
        chk("reset_outs",
            {phi_inc_o, step_idx_o, nco_clken_o, settled_o, busy_o,
             done_o, aborted_o} == '0,
            {phi_inc_o, step_idx_o, nco_clken_o, settled_o, busy_o,
             done_o, aborted_o}, 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready_idle", cmd_ready == 1'b1, 64'(cmd_ready), 64'd1);
        @(posedge clk);
        #1;

        // basic sweep, then back-to-back wrap and negative step
        run(mk(32'h0CCCCCCD, 32'h01000000, 3, 4), 0, -1);
        run(mk(32'hFFFFFFF0, 32'h00000020, 2, 1), 0, -1);
        idle(2);
        run(mk(32'h00000000, 32'hFFFFFFFF, 2, 2), 0, -1);
        idle(1);

        // degenerate count and dwell
        run(mk(32'h12345678, 32'h11111111, 0, 3), 0, -1);
        run(mk(32'hA0000000, 32'h00000100, 3, 0), 0, -1);
        idle(1);

        // NCO valid arriving late
        run(mk(32'h40000000, 32'h00010000, 2, 3), 20, -1);
        idle(1);

        // abort in dwell of point 1, and on the very last dwell cycle
        run(mk(32'h0CCCCCCD, 32'h01000000, 3, 4), 0, 22);
        idle(1);
        run(mk(32'h55555555, 32'h00000003, 2, 3), 0, 22);
        idle(1);

        // abort with cmd_valid in IDLE must block accept
        cmd_valid = 1'b1;
        cmd_start = 32'h77777777;
        cmd_step  = 32'h1;
        cmd_count = 16'd2;
        cmd_dwell = 16'd2;
        abort     = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("abort_blocks_ready", cmd_ready == 1'b0, 64'(cmd_ready),
                64'd0);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        abort     = 1'b0;
        @(negedge clk);
        chk("abort_no_busy", !busy_o, 64'(busy_o), 64'd0);
        chk("abort_phi_hold", phi_inc_o == model_phi, 64'(phi_inc_o),
            64'(model_phi));
        @(posedge clk);
        #1;

        // reset in the middle of SETTLE
        offer(mk(32'hDEADBEEF, 32'h10, 3, 2), a, ok);
        idle(2);
        reset_n = 1'b0;
        @(negedge clk);
        chk("reset_mid_ready", cmd_ready == 1'b0, 64'(cmd_ready), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("reset_mid_outs",
            {phi_inc_o, step_idx_o, nco_clken_o, settled_o, busy_o,
             done_o, aborted_o} == '0,
            {phi_inc_o, step_idx_o, nco_clken_o, settled_o, busy_o,
             done_o, aborted_o}, 64'd0);
        model_phi = '0;
        idle(1);

        // randomized sweeps, some back-to-back, some aborted
        for (int i = 0; i < 10; i++) begin
            n  = $urandom_range(0, 4);
            d  = $urandom_range(0, 5);
            c  = mk($urandom, $urandom, n, d);
            ao = -1;
            if (n != 0 && $urandom_range(0, 3) == 0)
                ao = $urandom_range(2, n * (L + ((d == 0) ? 1 : d)));
            run(c, 0, ao);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end

        idle(4);
        chk("queue_drained", exp_q.size() == 0, 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
